// File: rtl/imm_gen_pipe.sv
// Two-stage RV32I immediate generator with valid/ready flow control, flush and an illegal-opcode counter.
// Optional macro IMM_GEN_UJ_EN enables U/UJ decoding; otherwise those opcodes decode as illegal.
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned BR_HALF = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_SB  = 3'd3;
`ifdef IMM_GEN_UJ_EN
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_UJ  = 3'd5;
`endif
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]      a_instr;
  logic             a_valid;
  logic [XLEN-1:0]  b_imm;
  logic [2:0]       b_fmt;
  logic             b_illegal;
  logic             b_valid;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      dec_raw;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;

  logic out_xfer, in_xfer, b_adv;

  assign out_xfer   = b_valid && out_ready_i;
  assign b_adv      = !b_valid || out_ready_i;
  assign in_ready_o = !flush_i && (!a_valid || b_adv);
  assign in_xfer    = in_valid_i && in_ready_o;

  // Every format fits in 32 bits sign-extended; widen to XLEN by signed cast.
  always_comb begin
    dec_raw     = '0;
    dec_fmt     = FMT_ILL;
    dec_illegal = 1'b1;
    case (a_instr[6:0])
      7'b0110011: begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
      end
      7'b0010011, 7'b0000011: begin
        dec_raw     = {{20{a_instr[31]}}, a_instr[31:20]};
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      7'b0100011: begin
        dec_raw     = {{20{a_instr[31]}}, a_instr[31:25], a_instr[11:7]};
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        if (BR_HALF != 0)
          dec_raw = {{20{a_instr[31]}}, a_instr[31], a_instr[7], a_instr[30:25], a_instr[11:8]};
        else
          dec_raw = {{19{a_instr[31]}}, a_instr[31], a_instr[7], a_instr[30:25], a_instr[11:8], 1'b0};
        dec_fmt     = FMT_SB;
        dec_illegal = 1'b0;
      end
`ifdef IMM_GEN_UJ_EN
      7'b0110111, 7'b0010111: begin
        dec_raw     = {a_instr[31:12], 12'b0};
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        if (BR_HALF != 0)
          dec_raw = {{12{a_instr[31]}}, a_instr[31], a_instr[19:12], a_instr[20], a_instr[30:21]};
        else
          dec_raw = {{11{a_instr[31]}}, a_instr[31], a_instr[19:12], a_instr[20], a_instr[30:21], 1'b0};
        dec_fmt     = FMT_UJ;
        dec_illegal = 1'b0;
      end
`endif
      default: ;
    endcase
    dec_imm = XLEN'($signed(dec_raw));
  end

`ifndef IMM_GEN_UJ_EN
  // Bits only U/UJ extraction would read.
  logic unused_uj_bits;
  assign unused_uj_bits = ^a_instr[19:12];
`endif

  // Pipeline registers and saturating counter; a transfer in a flush cycle still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_instr   <= '0;
      a_valid   <= 1'b0;
      b_imm     <= '0;
      b_fmt     <= '0;
      b_illegal <= 1'b0;
      b_valid   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_xfer && b_illegal && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + CNT_W'(1);
      if (flush_i) begin
        a_valid <= 1'b0;
        b_valid <= 1'b0;
      end else begin
        if (b_adv) begin
          b_valid <= a_valid;
          if (a_valid) begin
            b_imm     <= dec_imm;
            b_fmt     <= dec_fmt;
            b_illegal <= dec_illegal;
          end
        end
        if (in_xfer) begin
          a_valid <= 1'b1;
          a_instr <= instr_i;
        end else if (b_adv) begin
          a_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o   = b_valid;
  assign imm_o         = b_imm;
  assign fmt_o         = b_fmt;
  assign illegal_o     = b_illegal;
  assign illegal_cnt_o = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=32, BR_HALF=1, CNT_W=2); expectations follow IMM_GEN_UJ_EN.
module tb_imm_gen_pipe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
`ifdef IMM_GEN_UJ_EN
  localparam bit UJ_ON = 1'b1;
`else
  localparam bit UJ_ON = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0]      instr;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [CNT_W-1:0] illegal_cnt;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  bit               stalled = 1'b0;
  exp_t             held;

  imm_gen_pipe #(.XLEN(XLEN), .BR_HALF(1), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .fmt_o(fmt), .illegal_o(illegal), .illegal_cnt_o(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, tracks the counter and hold behaviour.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      cnt_model = '0;
      stalled   = 1'b0;
    end else begin
      chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_model));
      if (out_valid && stalled)
        chk("hold", 64'({imm, fmt, illegal}), 64'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'({imm, fmt, illegal}), 64'(e));
          if (e.ill && cnt_model != {CNT_W{1'b1}})
            cnt_model = cnt_model + CNT_W'(1);
        end
      end
      stalled = out_valid && !out_ready;
      held    = '{imm: imm, fmt: fmt, ill: illegal};
      if (flush) begin
        sb.delete();
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] e_imm,
                      input logic [2:0] e_fmt, input logic e_ill);
    bit done = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    instr    = ins;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{imm: e_imm, fmt: e_fmt, ill: e_ill});
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  // U/UJ vectors become illegal when the feature is compiled out.
  task automatic send_uj(input logic [31:0] ins, input logic [XLEN-1:0] e_imm, input logic [2:0] e_fmt);
    if (UJ_ON) send(ins, e_imm, e_fmt, 1'b0);
    else       send(ins, '0, 3'd7, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(n < 50), 64'(1));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outs", 64'({imm, fmt, illegal, illegal_cnt}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // addi x1,x0,-1 with latency check
    send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    chk("lat_edge1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_edge2", 64'(out_valid), 64'(1));
    drain();

    // sw then beq back-to-back
    send(32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0);
    send(32'hFE000CE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    drain();

    send_uj(32'h123450B7, 32'h12345000, 3'd4);
    drain();

    send_uj(32'h0080006F, 32'h00000004, 3'd5);
    send_uj(32'hFFDFF06F, 32'hFFFFFFFE, 3'd5);
    send(32'h002081B3, 32'h00000000, 3'd0, 1'b0);
    send_uj(32'h00001097, 32'h00001000, 3'd4);
    send(32'h0040A103, 32'h00000004, 3'd1, 1'b0);
    drain();

    // Stall: two accepted, third waits until out_ready rises
    out_ready = 1'b0;
    send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send(32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(in_ready), 64'(1));
    send(32'hFE000CE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    drain();

    // Flush two stalled illegal entries
    out_ready = 1'b0;
    send(32'h0000007F, '0, 3'd7, 1'b1);
    send(32'h0000007F, '0, 3'd7, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("flush_stays_empty", 64'(out_valid), 64'(0));

    // Flush coinciding with an output transfer: the delivered entry still counts
    send(32'h0000007F, '0, 3'd7, 1'b1);
    send(32'h0000007F, '0, 3'd7, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_xfer_out_valid", 64'(out_valid), 64'(0));
    drain();

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send(32'h0000007F, '0, 3'd7, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_outs", 64'({imm, fmt, illegal, illegal_cnt}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));

    // Counter saturation with CNT_W=2
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h0000007F, '0, 3'd7, 1'b1);
    drain();
    @(posedge clk); #1;
    chk("cnt_saturated", 64'(illegal_cnt), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
